// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the RV64M divide issue/retire slice:
//   - mdu_op_e     : divider operation encoding (matches the divider ALUctr)
//   - INT32_MIN / INT64_MIN : most-negative operands used for overflow checks
//   - mdu_entry_t  : one queued divide op, including its precomputed special
//                    flag and special result
//   - is_signed_op / is_rem_op : small decode helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

  // Datapath width of the divider this slice feeds (RV64).
  localparam int MDU_XLEN = 64;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } mdu_op_e;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic [MDU_XLEN-1:0] src1;
    logic [MDU_XLEN-1:0] src2;
    mdu_op_e             op;
    logic                is_w;
    logic [4:0]          rd;
    logic                special;
    logic [MDU_XLEN-1:0] spec_result;
  } mdu_entry_t;

  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input mdu_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/mdu_div_special.sv
// -----------------------------------------------------------------------------
// mdu_div_special
// Combinational classifier sitting on the issue FIFO write port. Flags the
// RISC-V divide corner cases that never go to the divider and produces their
// architectural result:
//   divide by zero : div/divu -> all ones, rem/remu -> dividend
//   signed overflow: div -> dividend, rem -> 0   (INT_MIN / -1, div/rem only)
// For *W ops the checks use the low 32 bits and the result is the 32-bit
// value sign-extended to 64 bits (unsigned *W ops included).
//
// Ports:
//   src1, src2 : dividend / divisor as presented by EX
//   op         : operation encoding
//   is_w       : 32-bit variant
//   special    : op is resolved here, not by the divider
//   result     : special result (don't-care when special is low)
// -----------------------------------------------------------------------------
module mdu_div_special
  import mdu_pkg::*;
(
  input  logic [MDU_XLEN-1:0] src1,
  input  logic [MDU_XLEN-1:0] src2,
  input  mdu_op_e             op,
  input  logic                is_w,
  output logic                special,
  output logic [MDU_XLEN-1:0] result
);

  logic                div_zero;
  logic                overflow;
  logic                rem_op;
  logic [MDU_XLEN-1:0] raw;

  always_comb begin
    rem_op = is_rem_op(op);

    if (is_w) begin
      div_zero = (src2[31:0] == 32'd0);
      overflow = is_signed_op(op) && (src1[31:0] == INT32_MIN) &&
                 (src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      div_zero = (src2 == '0);
      overflow = is_signed_op(op) && (src1 == INT64_MIN) && (src2 == '1);
    end

    // The two cases are disjoint (a -1 divisor is never zero), so the
    // priority here is only for readability.
    raw = '0;
    if (div_zero) begin
      raw = rem_op ? src1 : '1;
    end else if (overflow) begin
      raw = rem_op ? '0 : src1;
    end

    special = div_zero || overflow;
    result  = is_w ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

endmodule

// File: rtl/mdu_div_issue.sv
// -----------------------------------------------------------------------------
// mdu_div_issue
// Issue/retire stage in front of the single-cycle RV64M divider. Ops from EX
// are queued in a small in-order FIFO. Normal ops are dispatched to the
// divider; divide-by-zero and signed-overflow ops are resolved locally and
// retired through a one-entry special register. All results leave through a
// single writeback port in program order, tagged with rd.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_*              : op from EX (valid/ready handshake)
//   dv_valid_in/ready : dispatch handshake to the divider
//   dv_src1/2, dv_ctr, dv_is_w : divider operands and control
//   dv_block          : stall to divider (mirrors wb_block)
//   dv_valid/result   : divider result, one cycle after dispatch
//   wb_valid/block    : result handshake to writeback
//   wb_data, wb_rd    : result and destination tag
// -----------------------------------------------------------------------------
module mdu_div_issue
  import mdu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [1:0]      in_op,
  input  logic            in_is_w,
  input  logic [4:0]      in_rd,

  output logic            dv_valid_in,
  input  logic            dv_ready,
  output logic [XLEN-1:0] dv_src1,
  output logic [XLEN-1:0] dv_src2,
  output logic [1:0]      dv_ctr,
  output logic            dv_is_w,
  output logic            dv_block,
  input  logic            dv_valid,
  input  logic [XLEN-1:0] dv_result,

  output logic            wb_valid,
  input  logic            wb_block,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd
);

  localparam int AW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mdu_entry_t          mem_q [DEPTH];
  mdu_entry_t          mem_d [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                pend_v_q, pend_v_d;
  logic [4:0]          pend_rd_q, pend_rd_d;
  logic                spec_v_q, spec_v_d;
  logic [XLEN-1:0]     spec_data_q, spec_data_d;
  logic [4:0]          spec_rd_q, spec_rd_d;

  // ---------------------------------------------------------------------------
  // Write-port classification
  // ---------------------------------------------------------------------------
  logic                in_special;
  logic [MDU_XLEN-1:0] in_spec_result;
  mdu_entry_t          new_entry;

  mdu_div_special u_special (
    .src1    (in_src1),
    .src2    (in_src2),
    .op      (mdu_op_e'(in_op)),
    .is_w    (in_is_w),
    .special (in_special),
    .result  (in_spec_result)
  );

  always_comb begin
    new_entry.src1        = in_src1;
    new_entry.src2        = in_src2;
    new_entry.op          = mdu_op_e'(in_op);
    new_entry.is_w        = in_is_w;
    new_entry.rd          = in_rd;
    new_entry.special     = in_special;
    new_entry.spec_result = in_spec_result;
  end

  // ---------------------------------------------------------------------------
  // FIFO status and head
  // ---------------------------------------------------------------------------
  logic       full;
  logic       empty;
  mdu_entry_t head;

  // Pointers carry one extra wrap bit: equal indices with differing wrap bits
  // means full, identical pointers means empty.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // in_ready depends only on registered state, so a pop in the same cycle
  // never reaches back into EX combinationally.
  assign in_ready = !full;

  // ---------------------------------------------------------------------------
  // Dispatch / special retire / drain decisions
  // ---------------------------------------------------------------------------
  logic push;
  logic dv_fire;
  logic spec_drain;
  logic pend_drain;
  logic spec_fire;
  logic pop;

  assign push       = in_valid && in_ready;
  assign spec_drain = spec_v_q && !wb_block;
  assign pend_drain = pend_v_q && dv_valid && !wb_block;

  // Normal ops wait behind a special result still sitting in the spec
  // register; that is what keeps a later normal op from overtaking it.
  assign dv_valid_in = !empty && !head.special && !spec_v_q;
  assign dv_fire     = dv_valid_in && dv_ready;

  // A special op only retires once no divider result is outstanding, so it
  // can never pass an older normal op.
  assign spec_fire = !empty && head.special && !pend_v_q &&
                     (!spec_v_q || spec_drain);

  assign pop = dv_fire || spec_fire;

  // ---------------------------------------------------------------------------
  // Divider and writeback outputs
  // ---------------------------------------------------------------------------
  assign dv_src1  = head.src1;
  assign dv_src2  = head.src2;
  assign dv_ctr   = head.op;
  assign dv_is_w  = head.is_w;
  assign dv_block = wb_block;

  // pend_v and spec_v are mutually exclusive, so spec_v alone picks the path.
  assign wb_valid = (pend_v_q && dv_valid) || spec_v_q;
  assign wb_data  = spec_v_q ? spec_data_q : dv_result;
  assign wb_rd    = spec_v_q ? spec_rd_q : pend_rd_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = new_entry;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // A dispatch in the same cycle as a drain keeps pend_v set.
    pend_v_d  = pend_v_q;
    pend_rd_d = pend_rd_q;
    if (dv_fire) begin
      pend_v_d  = 1'b1;
      pend_rd_d = head.rd;
    end else if (pend_drain) begin
      pend_v_d  = 1'b0;
    end

    spec_v_d    = spec_v_q;
    spec_data_d = spec_data_q;
    spec_rd_d   = spec_rd_q;
    if (spec_fire) begin
      spec_v_d    = 1'b1;
      spec_data_d = head.spec_result;
      spec_rd_d   = head.rd;
    end else if (spec_drain) begin
      spec_v_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: only control state is reset; payloads are qualified by valids.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    mem_q       <= mem_d;
    pend_rd_q   <= pend_rd_d;
    spec_data_q <= spec_data_d;
    spec_rd_q   <= spec_rd_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_v_q <= 1'b0;
      spec_v_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_v_q <= pend_v_d;
      spec_v_q <= spec_v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // A divider result must belong to an outstanding dispatch. The first cycle
  // after reset is exempt: a dispatch launched while reset was asserted still
  // lands then and is intentionally discarded.
  a_dv_valid_pend: assert property (@(posedge clk) disable iff (rst)
    (dv_valid && !$past(rst)) |-> pend_v_q);

  a_pend_spec_excl: assert property (@(posedge clk) disable iff (rst)
    !(pend_v_q && spec_v_q));

endmodule

// File: tb/tb_mdu_div_issue.sv
// -----------------------------------------------------------------------------
// tb_mdu_div_issue
// Self-checking bench for mdu_div_issue with a behavioural single-cycle
// divider attached. Expected results come from a plain-arithmetic RV64M
// reference and an in-order queue of expected {rd, data}.
// -----------------------------------------------------------------------------
module tb_mdu_div_issue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam logic [63:0] POISON = 64'hBADC_0FFE_E0DD_F00D;
  localparam logic [63:0] I64MIN = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_src1 = '0;
  logic [XLEN-1:0] in_src2 = '0;
  logic [1:0]      in_op = 2'b00;
  logic            in_is_w = 1'b0;
  logic [4:0]      in_rd = '0;
  logic            dv_valid_in;
  logic            dv_ready;
  logic [XLEN-1:0] dv_src1, dv_src2;
  logic [1:0]      dv_ctr;
  logic            dv_is_w;
  logic            dv_block;
  logic            dv_valid;
  logic [XLEN-1:0] dv_result;
  logic            wb_valid;
  logic            wb_block = 1'b0;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;

  always #5 clk = ~clk;

  mdu_div_issue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op),
    .in_is_w(in_is_w), .in_rd(in_rd),
    .dv_valid_in(dv_valid_in), .dv_ready(dv_ready),
    .dv_src1(dv_src1), .dv_src2(dv_src2), .dv_ctr(dv_ctr),
    .dv_is_w(dv_is_w), .dv_block(dv_block),
    .dv_valid(dv_valid), .dv_result(dv_result),
    .wb_valid(wb_valid), .wb_block(wb_block),
    .wb_data(wb_data), .wb_rd(wb_rd)
  );

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic ref_special(input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] op, input logic w);
    logic sgn, zero, ovf;
    sgn  = (op == 2'b00) || (op == 2'b10);
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == I64MIN && b == '1));
    return zero || ovf;
  endfunction

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic w);
    int          sa, sb;
    logic [31:0] ua, ub, r32;
    longint      sla, slb;
    logic [63:0] r;
    logic        sgn, is_rem;
    sgn    = (op == 2'b00) || (op == 2'b10);
    is_rem = op[1];
    r32    = '0;
    r      = '0;
    if (w) begin
      ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb = b[31:0];
      if (ub == 32'd0)                                   r32 = is_rem ? ua : 32'hFFFF_FFFF;
      else if (sgn && ua == 32'h8000_0000 && sb == -1)   r32 = is_rem ? 32'd0 : ua;
      else if (sgn && is_rem)                            r32 = sa % sb;
      else if (sgn)                                      r32 = sa / sb;
      else if (is_rem)                                   r32 = ua % ub;
      else                                               r32 = ua / ub;
      r = {{32{r32[31]}}, r32};
    end else begin
      sla = a; slb = b;
      if (b == 64'd0)                                    r = is_rem ? a : '1;
      else if (sgn && a == I64MIN && slb == -1)          r = is_rem ? 64'd0 : a;
      else if (sgn && is_rem)                            r = sla % slb;
      else if (sgn)                                      r = sla / slb;
      else if (is_rem)                                   r = a % b;
      else                                               r = a / b;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Divider model: one-cycle latency, holds its result while blocked.
  // Returns a poison value for corner-case operands so any wrongly
  // dispatched special op shows up as a data error.
  // ---------------------------------------------------------------------------
  logic        dvr_valid = 1'b0;
  logic [63:0] dvr_result = '0;

  assign dv_ready  = !(dv_block && dvr_valid);
  assign dv_valid  = dvr_valid;
  assign dv_result = dvr_result;

  always @(posedge clk) begin
    if (!(dv_block && dvr_valid)) begin
      dvr_valid  <= dv_valid_in;
      dvr_result <= ref_special(dv_src1, dv_src2, dv_ctr, dv_is_w) ? POISON
                    : ref_div(dv_src1, dv_src2, dv_ctr, dv_is_w);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] rd_log[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_disp = 0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (dv_valid_in && dv_ready) n_disp++;
      if (wb_valid && !wb_block) begin
        rd_log.push_back(wb_rd);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h, expected no result",
                   wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wb_data", wb_data, e.data);
          checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
        end
      end
      if (in_valid && in_ready) begin
        e.rd   = in_rd;
        e.data = ref_div(in_src1, in_src2, in_op, in_is_w);
        exp_q.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] op, input logic w, input logic [4:0] rd);
    in_src1 = a; in_src2 = b; in_op = op; in_is_w = w; in_rd = rd;
  endtask

  // Holds in_valid until accepted (bounded), returns just after the push edge.
  task automatic push_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic w, input logic [4:0] rd);
    bit ok;
    ok = 1'b0;
    applyStimulus(a, b, op, w, rd);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick();
    checkOutput("all_results_retired", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        w;
    logic [4:0]  rd;
    logic [63:0] res;
    logic        special;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          d0;
    bit          acc;
    int          sel;
    logic [63:0] ra, rb;
    logic        rw;

    vecs[0]  = '{64'd100, 64'd7, 2'b00, 1'b0, 5'd5, 64'd14, 1'b0};
    vecs[1]  = '{64'd5, 64'h1_0000_0000, 2'b01, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 2'b10, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFF7, 1'b1};
    vecs[3]  = '{I64MIN, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 5'd8, I64MIN, 1'b1};
    vecs[4]  = '{64'h8000_0000, 64'hFFFF_FFFF, 2'b10, 1'b1, 5'd9, 64'd0, 1'b1};
    vecs[5]  = '{64'd100, 64'd7, 2'b11, 1'b0, 5'd10, 64'd2, 1'b0};
    vecs[6]  = '{64'hFFFF_FFF9, 64'd2, 2'b00, 1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[7]  = '{64'hFFFF_FFF9, 64'd2, 2'b01, 1'b1, 5'd12, 64'h0000_0000_7FFF_FFFC, 1'b0};
    vecs[8]  = '{64'h1_8000_0001, 64'h1_0000_0000, 2'b11, 1'b1, 5'd13, 64'hFFFF_FFFF_8000_0001, 1'b1};
    vecs[9]  = '{I64MIN, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 5'd14, 64'd0, 1'b0};
    vecs[10] = '{64'h8000_0000, 64'hFFFF_FFFF, 2'b00, 1'b1, 5'd15, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[11] = '{64'd0, 64'd0, 2'b01, 1'b0, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[12] = '{64'd5, 64'h1_0000_0000, 2'b01, 1'b0, 5'd17, 64'd0, 1'b0};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_dv_valid_in", 64'(dv_valid_in), 64'd0);
    checkOutput("reset_wb_valid", 64'(wb_valid), 64'd0);
    tick();

    // Isolated ops with exact latency: dispatch 1 cycle, result 2 cycles after push
    foreach (vecs[i]) begin
      d0 = n_disp;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].w, vecs[i].rd);
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput("vec_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("vec_dv_valid_in", 64'(dv_valid_in), 64'(!vecs[i].special));
      if (!vecs[i].special) begin
        checkOutput("vec_dv_src1", dv_src1, vecs[i].a);
        checkOutput("vec_dv_ctr", 64'(dv_ctr), 64'(vecs[i].op));
      end
      tick();
      @(negedge clk);
      checkOutput("vec_wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("vec_wb_data", wb_data, vecs[i].res);
      checkOutput("vec_wb_rd", 64'(wb_rd), 64'(vecs[i].rd));
      tick();
      checkOutput("vec_dispatch_count", 64'(n_disp - d0), 64'(!vecs[i].special));
    end

    // Ordering: normal, special, normal back-to-back
    rd_log.delete();
    push_op(64'd100, 64'd7, 2'b00, 1'b0, 5'd1);
    push_op(64'd5, 64'd0, 2'b00, 1'b0, 5'd2);
    push_op(64'd1000, 64'd10, 2'b01, 1'b0, 5'd3);
    drain();
    checkOutput("order_count", 64'(rd_log.size()), 64'd3);
    if (rd_log.size() == 3) begin
      checkOutput("order_0", 64'(rd_log[0]), 64'd1);
      checkOutput("order_1", 64'(rd_log[1]), 64'd2);
      checkOutput("order_2", 64'(rd_log[2]), 64'd3);
    end

    // Writeback stall: result held stable, FIFO fills, nothing lost after release
    rd_log.delete();
    wb_block = 1'b1;
    push_op(64'd91, 64'd13, 2'b00, 1'b0, 5'd20);
    push_op(64'd50, 64'd8, 2'b10, 1'b0, 5'd21);
    push_op(64'd77, 64'd0, 2'b01, 1'b0, 5'd22);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("blk_wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("blk_wb_data", wb_data, 64'd7);
      checkOutput("blk_wb_rd", 64'(wb_rd), 64'd20);
      checkOutput("blk_in_ready", 64'(in_ready), 64'd0);
      checkOutput("blk_dv_block", 64'(dv_block), 64'd1);
      tick();
    end
    wb_block = 1'b0;
    drain();
    checkOutput("blk_count", 64'(rd_log.size()), 64'd3);
    if (rd_log.size() == 3) begin
      checkOutput("blk_order_0", 64'(rd_log[0]), 64'd20);
      checkOutput("blk_order_1", 64'(rd_log[1]), 64'd21);
      checkOutput("blk_order_2", 64'(rd_log[2]), 64'd22);
    end

    // Reset with FIFO full and a held divider result
    wb_block = 1'b1;
    push_op(64'd40, 64'd3, 2'b00, 1'b0, 5'd25);
    push_op(64'd41, 64'd3, 2'b00, 1'b0, 5'd26);
    push_op(64'd42, 64'd3, 2'b00, 1'b0, 5'd27);
    @(negedge clk);
    checkOutput("prerst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b1;
    wb_block = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("postrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("postrst_dv_valid_in", 64'(dv_valid_in), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postrst_quiet", 64'(wb_valid), 64'd0);
      tick();
    end
    push_op(64'd99, 64'd9, 2'b01, 1'b0, 5'd30);
    drain();

    // Randomized traffic with random writeback stalls
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        if (in_valid) begin
          sel = $urandom_range(0, 7);
          rw  = $urandom_range(0, 1) == 1;
          ra  = {$urandom, $urandom};
          rb  = {$urandom, $urandom};
          if (sel == 0) rb = rw ? {rb[63:32], 32'd0} : 64'd0;
          if (sel == 1) begin
            if (rw) begin
              ra = {ra[63:32], 32'h8000_0000};
              rb = {rb[63:32], 32'hFFFF_FFFF};
            end else begin
              ra = I64MIN;
              rb = '1;
            end
          end
          if (sel == 2) rb = 64'($urandom_range(1, 15));
          applyStimulus(ra, rb, 2'($urandom_range(0, 3)), rw, 5'($urandom_range(0, 31)));
        end
      end
      wb_block = ($urandom_range(0, 3) == 0);
    end
    in_valid = 1'b0;
    wb_block = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mdu_div_issue.md
Name: mdu_div_issue

Overview:
- Issue/retire stage directly upstream of the single-cycle RV64M divider. Also owns the divider's result path to writeback.
- Accepts divide/remainder ops from EX through a small in-order FIFO and dispatches normal ops to the divider.
- Resolves RISC-V special cases locally without using the divider: divide-by-zero and signed overflow.
- Returns every result to writeback in program order, tagged with rd.

Parameters:
- DEPTH, 2: input FIFO entries; power of two, at least 2.
- XLEN, 64: operand width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EX presents an op
- in_ready  out  1  FIFO can accept
- in_src1  in  XLEN  dividend
- in_src2  in  XLEN  divisor
- in_op  in  2  00 div, 01 divu, 10 rem, 11 remu
- in_is_w  in  1  32-bit (*W) variant
- in_rd  in  5  destination register
- dv_valid_in  out  1  dispatch strobe to divider
- dv_ready  in  1  divider ready (~(block&&valid))
- dv_src1, dv_src2  out  XLEN  operands to divider
- dv_ctr  out  2  divider ALUctr (= op)
- dv_is_w  out  1  divider is_w
- dv_block  out  1  stall to divider (= wb_block)
- dv_valid  in  1  divider result valid
- dv_result  in  XLEN  divider result
- wb_valid  out  1  result available to writeback
- wb_block  in  1  writeback stall
- wb_data  out  XLEN  result
- wb_rd  out  5  result tag

Behaviour:
- Reset: FIFO empty, pend_v=0, spec_v=0. Resulting outputs: in_ready=1, dv_valid_in=0, wb_valid=0. Data outputs may hold any value while their valid is low.
- Reset mid-operation flushes everything. Any divider result arriving in the cycle after reset is dropped because pend_v=0.

FIFO:
- Push when in_valid&&in_ready; in_ready = !full.
- Push and pop in the same cycle is legal when full; in_ready stays tied to !full, with no combinational path from pop.
- Pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty.
- Entry stores src1, src2, op, is_w, rd, plus a precomputed special flag and special result.

Special classification (at push), with w = in_is_w:
- Divisor zero: src2[31:0]==0 when w, else src2==0.
  - div/divu result = all ones.
  - rem/remu result = dividend.
- Signed overflow, op 00/10 only: dividend == INT_MIN and divisor == -1, at 32 or 64 bits per w.
  - div result = dividend.
  - rem result = 0.
- For w, special results are the 32-bit value sign-extended to 64 bits. This applies to divu/remu too: divu-w by zero gives 0xFFFF_FFFF_FFFF_FFFF.

Dispatch:
- Head non-special, FIFO non-empty, spec_v==0: dv_valid_in=1.
- Pop and set pend_v<=1, pend_rd<=rd when dv_ready=1.

Special retire:
- Head special, pend_v==0, and (spec_v==0 or the spec entry drains this cycle): pop into spec register (spec_v<=1, data, rd).
- An op never overtakes an in-flight divider result, which preserves order.

Writeback mux:
- wb_valid = (pend_v && dv_valid) || spec_v.
- pend_v and spec_v are never simultaneously set.
- pend path: wb_data = dv_result, wb_rd = pend_rd.
- spec path: wb_data = spec data, wb_rd = spec rd.
- Drain when wb_valid && !wb_block. Draining clears pend_v unless a new dispatch in the same cycle re-sets it; dispatch wins.

Stall:
- dv_block = wb_block. The divider holds its result, and dv_ready drops while it is held.
- spec_v holds while wb_block=1.

Throughput and latency:
- Back-to-back normal ops: 1 per cycle.
- Push to wb_valid = 2 cycles minimum.
- Special op following a normal op waits until pend_v clears.

Invariant (assert): dv_valid implies pend_v.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11
  - entry struct
  - INT32_MIN/INT64_MIN constants
- One sub-module: mdu_div_special. It is combinational classification plus special-result generation, instantiated at the FIFO write port.
- FIFO storage is inline.

Test Plan:
- Reset then single div, src1=100, src2=7, op 00 -> dv_valid_in high 1 cycle after push; wb_valid next cycle with wb_data=14, correct rd.
- divu-w src1=5, src2=0x1_0000_0000 (low word zero) -> divider never dispatched; wb_data=0xFFFF_FFFF_FFFF_FFFF. rem 64-bit src1=-9, src2=0 -> wb_data=-9.
- Overflow: div src1=0x8000_0000_0000_0000, src2=-1 -> wb_data=0x8000_0000_0000_0000. rem-w src1=0x8000_0000, src2=0xFFFF_FFFF -> 0.
- Sequence normal(rd=1), special(rd=2), normal(rd=3) pushed back-to-back -> wb_rd order 1,2,3; special retires only after rd=1 drains.
- wb_block held 3 cycles during results -> wb_data/wb_rd stable; dv_block high; FIFO fills to DEPTH; in_ready=0; nothing lost or duplicated after release.
- rst asserted with FIFO full and divider result pending -> next cycle wb_valid=0, in_ready=1, no stale result emitted.
